// File: rtl/iteration_pixel_writer.sv
// Pulls Mandelbrot iteration counts from the rendering engine and writes
// them as RGB332 pixels into a linearly addressed frame buffer.
module iteration_pixel_writer #(
    parameter int HBI       = 32,
    parameter int ADDR_W    = 19,
    parameter int X_SIZE    = 640,
    parameter int Y_SIZE    = 480,
    parameter int BASE_ADDR = 0,
    parameter int MAX_ITER  = 255
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              frame_req,
    output logic              start_render,
    input  logic [HBI-1:0]    data,
    input  logic              ready,
    input  logic              frame_ready,
    output logic              send_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    input  logic              mem_busy,
    output logic              frame_done,
    output logic              err
);

    localparam int TOTAL = X_SIZE * Y_SIZE;
    localparam int CNT_W = $clog2(TOTAL + 1);

    localparam logic [CNT_W-1:0]  TOTAL_V    = CNT_W'(TOTAL);
    localparam logic [ADDR_W-1:0] BASE_V     = ADDR_W'(BASE_ADDR);
    localparam logic [HBI-1:0]    MAX_ITER_V = HBI'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FETCH,
        S_WRITE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [HBI-1:0]   iter_q;
    logic             err_q;

    logic accept;
    logic fetch_take;
    logic write_done;
    logic last_pixel;
    logic early_eof;

    assign accept     = (state == S_IDLE)  && frame_req;
    assign fetch_take = (state == S_FETCH) && ready && !mem_busy;
    assign write_done = (state == S_WRITE) && !mem_busy;
    assign early_eof  = (state == S_FETCH) && !ready && frame_ready;
    assign cnt_next   = pix_cnt + CNT_W'(1);
    assign last_pixel = (cnt_next == TOTAL_V);

    // NOTE: sequential state uses non-blocking assignments only; reset is
    // synchronous, so it is tested inside the clocked block.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: state_nxt gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (frame_req) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                state_nxt = S_FETCH;
            end
            S_FETCH: begin
                if (ready && !mem_busy) begin
                    state_nxt = S_WRITE;
                end else if (frame_ready && !ready) begin
                    state_nxt = S_DONE;
                end
            end
            S_WRITE: begin
                // The last pixel goes straight to DONE, never consuming an extra sample.
                if (!mem_busy) begin
                    state_nxt = last_pixel ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        start_render = 1'b0;
        send_data    = 1'b0;
        mem_we       = 1'b0;
        frame_done   = 1'b0;
        case (state)
            S_START: start_render = 1'b1;
            S_FETCH: send_data    = ready && !mem_busy;
            S_WRITE: mem_we       = 1'b1;
            S_DONE:  frame_done   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pix_cnt <= '0;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                pix_cnt <= '0;
            end else if (write_done) begin
                pix_cnt <= cnt_next;
            end

            if (fetch_take) begin
                iter_q <= data;
            end

            if (accept) begin
                err_q <= 1'b0;
            end else if (early_eof && (pix_cnt != TOTAL_V)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Address and pixel are pure functions of registered state, so they hold
    // steady for as long as the memory stalls.
    assign mem_addr  = BASE_V + ADDR_W'(pix_cnt);
    assign mem_wdata = (iter_q >= MAX_ITER_V) ? 8'h00
                                              : {iter_q[2:0], iter_q[5:3], iter_q[7:6]};
    assign err       = err_q;

endmodule

// File: tb/tb_iteration_pixel_writer.sv
// Randomized bench for iteration_pixel_writer: an engine/memory model drives
// the DUT and a transaction-level model predicts every output each cycle.
module tb_iteration_pixel_writer;

    localparam int HBI       = 32;
    localparam int ADDR_W    = 19;
    localparam int X_SIZE    = 4;
    localparam int Y_SIZE    = 2;
    localparam int TOTAL     = X_SIZE * Y_SIZE;
    localparam int BASE_ADDR = 0;
    localparam int MAX_ITER  = 255;

    logic              CLK = 1'b0;
    logic              RST;
    logic              frame_req;
    logic              start_render;
    logic [HBI-1:0]    data;
    logic              ready;
    logic              frame_ready;
    logic              send_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_we;
    logic              mem_busy;
    logic              frame_done;
    logic              err;

    always #5 CLK = ~CLK;

    iteration_pixel_writer #(
        .HBI(HBI), .ADDR_W(ADDR_W), .X_SIZE(X_SIZE), .Y_SIZE(Y_SIZE),
        .BASE_ADDR(BASE_ADDR), .MAX_ITER(MAX_ITER)
    ) dut (
        .CLK(CLK), .RST(RST), .frame_req(frame_req), .start_render(start_render),
        .data(data), .ready(ready), .frame_ready(frame_ready), .send_data(send_data),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_busy(mem_busy), .frame_done(frame_done), .err(err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RGB332 palette: red <- count mod 8, green <- (count/8) mod 8, blue <- (count/64) mod 4.
    function automatic logic [7:0] colour(input logic [HBI-1:0] v);
        int r, g, b;
        if (v >= MAX_ITER) return 8'h00;
        r = int'(v % 8);
        g = int'((v / 8) % 8);
        b = int'((v / 64) % 4);
        return 8'(r * 32 + g * 4 + b);
    endfunction

    // Engine / memory model and expectation state
    logic [HBI-1:0] pix [TOTAL];
    logic [7:0]     wd_log [TOTAL];
    int  we_cnt [TOTAL];
    int  avail, cons, writes, strobes, starts, frame_dones;
    bit  eng_on, in_frame, exp_err;
    bit  p_accept, p_send, p_we, p_busy, p_rst, p_last_done, p_fetch_eof;
    int  ready_mode, busy_mode, stall_idx, stall_left;
    bit  drive_req, drive_rst;

    task automatic model_reset();
        eng_on = 0; in_frame = 0; exp_err = 0; cons = 0; writes = 0;
        p_accept = 0; p_send = 0; p_we = 0; p_busy = 0;
        p_last_done = 0; p_fetch_eof = 0;
    endtask

    task automatic cycle();
        bit e_start, e_we, e_done, e_send, waiting, completing;
        @(negedge CLK);
        e_start = p_accept;
        e_we    = p_send || (p_we && p_busy);
        e_done  = p_last_done || p_fetch_eof;

        RST         = drive_rst;
        frame_req   = drive_req;
        frame_ready = eng_on && (cons >= avail);
        ready       = eng_on && (cons < avail) && (ready_mode == 1 || $urandom_range(0, 2) != 0);
        data        = ready ? pix[cons] : HBI'($urandom);
        case (busy_mode)
            1: mem_busy = ($urandom_range(0, 3) == 0);
            2: begin
                mem_busy = e_we && (writes == stall_idx) && (stall_left > 0);
                if (mem_busy) stall_left--;
            end
            default: mem_busy = 1'b0;
        endcase
        #1;

        if (p_rst) begin
            check("rst_addr", mem_addr, BASE_ADDR);
            check("rst_wdata", mem_wdata, 0);
        end
        if (e_done) exp_err = (writes != TOTAL);
        waiting = in_frame && !e_start && !e_we && !e_done;
        e_send  = waiting && ready && !mem_busy;

        check("start_render", start_render, e_start);
        check("mem_we", mem_we, e_we);
        check("frame_done", frame_done, e_done);
        check("send_data", send_data, e_send);
        check("send_spacing", send_data && p_send, 0);
        check("err", err, exp_err);
        if (e_we && writes < TOTAL) begin
            check("mem_addr", mem_addr, BASE_ADDR + writes);
            check("mem_wdata", mem_wdata, colour(pix[writes]));
        end

        completing = e_we && !mem_busy;
        if (e_we && writes < TOTAL) we_cnt[writes]++;
        if (completing && writes < TOTAL) wd_log[writes] = mem_wdata;
        p_last_done = completing && (writes + 1 == TOTAL);
        p_fetch_eof = waiting && frame_ready && !ready;
        if (completing) writes++;
        if (send_data) begin cons++; strobes++; end
        if (start_render) begin eng_on = 1; starts++; end
        p_accept = frame_req && !in_frame;
        if (e_done) begin frame_dones++; in_frame = 0; eng_on = 0; end
        if (p_accept) begin
            in_frame = 1; writes = 0; cons = 0; strobes = 0; starts = 0; exp_err = 0;
            for (int i = 0; i < TOTAL; i++) we_cnt[i] = 0;
        end
        p_send = e_send;
        p_we   = e_we;
        p_busy = mem_busy;
        p_rst  = RST;
        if (RST) model_reset();
    endtask

    task automatic run_frame(output int lat);
        int  d0;
        bit  seen;
        d0 = frame_dones;
        drive_req = 1; cycle(); drive_req = 0;
        lat = 0; seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            cycle();
            lat++;
            if (frame_dones != d0) seen = 1;
        end
        check("frame_done_seen", seen, 1);
    endtask

    function automatic logic [HBI-1:0] rand_iter();
        case ($urandom_range(0, 5))
            0: return HBI'($urandom);
            1: return HBI'(MAX_ITER);
            2: return HBI'(MAX_ITER - 1);
            3: return HBI'(MAX_ITER + 1);
            default: return HBI'($urandom_range(0, MAX_ITER - 1));
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        RST = 1; frame_req = 0; ready = 0; frame_ready = 0; data = '0; mem_busy = 0;
        drive_rst = 1; drive_req = 0; ready_mode = 1; busy_mode = 0;
        stall_idx = 0; stall_left = 0; avail = TOTAL;
        starts = 0; strobes = 0; frame_dones = 0;
        for (int i = 0; i < TOTAL; i++) we_cnt[i] = 0;
        model_reset();
        repeat (3) cycle();
        drive_rst = 0;
        repeat (3) cycle();

        // Always-ready engine, no stalls: palette pins and exact frame latency
        pix[0] = 255; pix[1] = 300; pix[2] = 0;   pix[3] = 9;
        pix[4] = 1;   pix[5] = 64;  pix[6] = 254; pix[7] = 200;
        run_frame(lat);
        check("lat_unstalled", lat, 18);
        check("writes_a", writes, 8);
        check("strobes_a", strobes, 8);
        check("starts_a", starts, 1);
        check("px0_255", wd_log[0], 8'h00);
        check("px1_300", wd_log[1], 8'h00);
        check("px2_0", wd_log[2], 8'h00);
        check("px3_9", wd_log[3], 8'h24);   // 9 -> {001,001,00}
        check("px5_64", wd_log[5], 8'h01);
        check("err_a", err, 0);
        repeat (2) cycle();

        // Three-cycle memory stall on pixel index 2
        for (int i = 0; i < TOTAL; i++) pix[i] = rand_iter();
        busy_mode = 2; stall_idx = 2; stall_left = 3;
        run_frame(lat);
        check("stall_we_cycles", we_cnt[2], 4);
        check("writes_stall", writes, 8);
        check("strobes_stall", strobes, 8);
        busy_mode = 0;
        repeat (2) cycle();

        // Engine ends after 6 pixels -> error; next frame clears it
        for (int i = 0; i < TOTAL; i++) pix[i] = rand_iter();
        avail = 6;
        run_frame(lat);
        check("writes_early", writes, 6);
        check("err_early", err, 1);
        cycle();
        check("err_sticky", err, 1);
        avail = TOTAL;
        run_frame(lat);
        check("err_cleared", err, 0);
        check("writes_after_err", writes, 8);
        repeat (2) cycle();

        // Reset in the write of the third pixel; mid-frame frame_req ignored
        drive_req = 1; cycle(); drive_req = 0;
        repeat (3) cycle();
        drive_req = 1; cycle(); drive_req = 0;
        for (int i = 0; i < 100 && !(p_send && writes == 2); i++) cycle();
        check("starts_midframe", starts, 1);
        check("reached_pixel3", p_send && writes == 2, 1);
        drive_rst = 1; cycle(); drive_rst = 0;
        repeat (4) cycle();
        run_frame(lat);
        check("writes_restart", writes, 8);
        repeat (2) cycle();

        // Randomized frames: random ready gaps, random stalls, random counts
        ready_mode = 0; busy_mode = 1;
        for (int f = 0; f < 15; f++) begin
            for (int i = 0; i < TOTAL; i++) pix[i] = rand_iter();
            run_frame(lat);
            check("writes_rand", writes, TOTAL);
            repeat ($urandom_range(0, 3)) cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
